// File: rtl/cpu_pkg.sv
// Shared encodings for the 8-phase RISC CPU: opcode and phase values plus field widths.
// Used by the controller, address_mux and datapath so every block agrees on the encoding.
// No logic beyond the ALU-opcode classification helper.
package cpu_pkg;

    localparam int OPCODE_W = 3;
    localparam int PHASE_W  = 3;

    // Opcode encodings
    localparam logic [OPCODE_W-1:0] HLT = 3'd0;
    localparam logic [OPCODE_W-1:0] SKZ = 3'd1;
    localparam logic [OPCODE_W-1:0] ADD = 3'd2;
    localparam logic [OPCODE_W-1:0] AND = 3'd3;
    localparam logic [OPCODE_W-1:0] XOR = 3'd4;
    localparam logic [OPCODE_W-1:0] LDA = 3'd5;
    localparam logic [OPCODE_W-1:0] STO = 3'd6;
    localparam logic [OPCODE_W-1:0] JMP = 3'd7;

    // Phase encodings; the counter walks these in order and wraps STORE -> INST_ADDR
    localparam logic [PHASE_W-1:0] INST_ADDR  = 3'd0;
    localparam logic [PHASE_W-1:0] INST_FETCH = 3'd1;
    localparam logic [PHASE_W-1:0] INST_LOAD  = 3'd2;
    localparam logic [PHASE_W-1:0] IDLE       = 3'd3;
    localparam logic [PHASE_W-1:0] OP_ADDR    = 3'd4;
    localparam logic [PHASE_W-1:0] OP_FETCH   = 3'd5;
    localparam logic [PHASE_W-1:0] ALU_OP     = 3'd6;
    localparam logic [PHASE_W-1:0] STORE      = 3'd7;

    // Opcodes whose result comes back through the ALU into the accumulator
    function automatic logic is_aluop(input logic [OPCODE_W-1:0] op);
        return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    endfunction

endpackage

// File: rtl/cpu_phase_counter.sv
// Free-running phase counter for the CPU sequencer, wraps 7 -> 0.
// Latency: phase_o is the registered count, advances one step per clock.
// hold_i freezes the count (used while the CPU is halted); no other stalls.
module cpu_phase_counter
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hold_i,
    output logic [PHASE_W-1:0] phase_o
);

    logic [PHASE_W-1:0] phase_q;
    logic [PHASE_W-1:0] phase_d;

    assign phase_d = hold_i ? phase_q : phase_q + 1'b1;

    // Phase register; natural overflow provides the 7 -> 0 wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= INST_ADDR;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign phase_o = phase_q;

endmodule

// File: rtl/cpu_controller.sv
// Sequencing controller: phase counter plus decode of phase/opcode/zero into datapath strobes.
// Latency: strobes are combinational from registered phase and halted flag; phase steps every clock.
// No backpressure; HLT freezes the phase at OP_ADDR until rst_n is asserted.
module cpu_controller
    import cpu_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    output logic                sel,
    output logic                rd,
    output logic                wr,
    output logic                ld_ir,
    output logic                ld_ac,
    output logic                ld_pc,
    output logic                inc_pc,
    output logic                data_e,
    output logic                halt,
    output logic [PHASE_W-1:0]  phase
);

    logic halted_q;
    logic halted_d;
    logic halt_now;
    logic aluop;

    // HLT seen at OP_ADDR: the counter must not step on this same edge, or it
    // would leave OP_ADDR before the halted flag takes effect
    assign halt_now = (phase == OP_ADDR) && (opcode == HLT) && !halted_q;
    assign halted_d = halted_q | halt_now;
    assign aluop    = is_aluop(opcode);

    cpu_phase_counter u_phase (
        .clk     (clk),
        .rst_n   (rst_n),
        .hold_i  (halted_d),
        .phase_o (phase)
    );

    // Sticky halted flag, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    // Strobe decode; while halted only halt and sel are driven so PC stays put
    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        wr     = 1'b0;
        ld_ir  = 1'b0;
        ld_ac  = 1'b0;
        ld_pc  = 1'b0;
        inc_pc = 1'b0;
        data_e = 1'b0;
        halt   = 1'b0;
        if (halted_q) begin
            sel  = 1'b1;
            halt = 1'b1;
        end else begin
            case (phase)
                INST_ADDR: begin
                    sel = 1'b0;
                end
                INST_FETCH: begin
                    rd = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    sel    = 1'b1;
                    inc_pc = 1'b1;
                    halt   = (opcode == HLT);
                end
                OP_FETCH: begin
                    sel = 1'b1;
                    rd  = aluop;
                end
                ALU_OP: begin
                    sel    = 1'b1;
                    rd     = aluop;
                    inc_pc = (opcode == SKZ) && zero;
                    ld_pc  = (opcode == JMP);
                    data_e = (opcode == STO);
                end
                STORE: begin
                    sel    = 1'b1;
                    rd     = aluop;
                    ld_ac  = aluop;
                    ld_pc  = (opcode == JMP);
                    wr     = (opcode == STO);
                    data_e = (opcode == STO);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_controller.sv
module tb_cpu_controller;
    import cpu_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [OPCODE_W-1:0] opcode;
    logic                zero;
    logic                sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt;
    logic [PHASE_W-1:0]  phase;

    cpu_controller dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .opcode (opcode),
        .zero   (zero),
        .sel    (sel),
        .rd     (rd),
        .wr     (wr),
        .ld_ir  (ld_ir),
        .ld_ac  (ld_ac),
        .ld_pc  (ld_pc),
        .inc_pc (inc_pc),
        .data_e (data_e),
        .halt   (halt),
        .phase  (phase)
    );

    always #5 clk = ~clk;

    // Expected vector layout: {phase[2:0], sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt}
    typedef struct {
        string       name;
        logic [11:0] v;
    } exp_t;

    // Per-signal masks over one instruction; bit p is the value in phase p
    typedef struct {
        logic [7:0] sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt;
    } masks_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    event sample_ev;
    logic wr_watch = 1'b0;
    int   wr_seen  = 0;

    function automatic masks_t mk(input logic [7:0] rd_m, wr_m, ld_ac_m, ld_pc_m,
                                  inc_m, de_m, halt_m);
        masks_t m;
        m.sel    = 8'hF0;
        m.ld_ir  = 8'h0C;
        m.rd     = rd_m;
        m.wr     = wr_m;
        m.ld_ac  = ld_ac_m;
        m.ld_pc  = ld_pc_m;
        m.inc_pc = inc_m;
        m.data_e = de_m;
        m.halt   = halt_m;
        return m;
    endfunction

    function automatic logic [11:0] vec(input int p, input masks_t m);
        logic [2:0] pp;
        pp = p[2:0];
        return {pp, m.sel[p], m.rd[p], m.wr[p], m.ld_ir[p], m.ld_ac[p],
                m.ld_pc[p], m.inc_pc[p], m.data_e[p], m.halt[p]};
    endfunction

    // Monitor: pops one expectation per negedge (or on demand for async events)
    initial begin
        exp_t e;
        logic [11:0] act;
        forever begin
            @(negedge clk or sample_ev);
            if (q.size() > 0) begin
                e   = q.pop_front();
                act = {phase, sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt};
                checks++;
                if (act !== e.v) begin
                    failures++;
                    $display("FAIL %s: actual {ph,sel,rd,wr,ldir,ldac,ldpc,incpc,de,halt}=%b_%b required=%b_%b",
                             e.name, act[11:9], act[8:0], e.v[11:9], e.v[8:0]);
                end
            end
        end
    end

    always @(wr) if (wr_watch && wr === 1'b1) wr_seen++;

    // Push an expectation for the current cycle, let the monitor compare, move to next cycle
    task automatic cycle(input string name, input logic [11:0] v);
        exp_t e;
        e.name = name;
        e.v    = v;
        q.push_back(e);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input string name, input logic [2:0] op, input logic z,
                             input masks_t m, input int nph);
        for (int p = 0; p < nph; p++) begin
            opcode = op;
            zero   = z;
            cycle($sformatf("%s_ph%0d", name, p), vec(p, m));
        end
    endtask

    task automatic check_now(input string name, input logic [11:0] v);
        exp_t e;
        e.name = name;
        e.v    = v;
        q.push_back(e);
        ->sample_ev;
        #1;
    endtask

    masks_t m_alu, m_sto, m_skz1, m_skz0, m_jmp, m_hlt;

    initial begin
        //              rd     wr     ld_ac  ld_pc  inc    de     halt
        m_alu  = mk(8'hEE, 8'h00, 8'h80, 8'h00, 8'h10, 8'h00, 8'h00);
        m_sto  = mk(8'h0E, 8'h80, 8'h00, 8'h00, 8'h10, 8'hC0, 8'h00);
        m_skz1 = mk(8'h0E, 8'h00, 8'h00, 8'h00, 8'h50, 8'h00, 8'h00);
        m_skz0 = mk(8'h0E, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00);
        m_jmp  = mk(8'h0E, 8'h00, 8'h00, 8'hC0, 8'h10, 8'h00, 8'h00);
        m_hlt  = mk(8'h0E, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h10);

        rst_n  = 1'b0;
        opcode = LDA;
        zero   = 1'b0;
        @(posedge clk);
        #1;
        cycle("reset_a", 12'h000);
        cycle("reset_b", 12'h000);
        rst_n = 1'b1;

        // Phase sequencing 0..7 then 0 and the main opcode classes
        run_instr("lda",  LDA, 1'b0, m_alu,  8);
        run_instr("sto",  STO, 1'b1, m_sto,  8);
        run_instr("skz1", SKZ, 1'b1, m_skz1, 8);
        run_instr("skz0", SKZ, 1'b0, m_skz0, 8);
        run_instr("jmp",  JMP, 1'b1, m_jmp,  8);
        run_instr("add",  ADD, 1'b1, m_alu,  8);
        run_instr("xor",  XOR, 1'b0, m_alu,  8);
        run_instr("and",  AND, 1'b0, m_alu,  8);

        // HLT: phases 0-4, then frozen at OP_ADDR with only halt and sel
        run_instr("hlt", HLT, 1'b0, m_hlt, 5);
        for (int i = 0; i < 20; i++) begin
            opcode = (i % 2 == 0) ? JMP : HLT;
            zero   = 1'b1;
            cycle($sformatf("halted_%0d", i), {3'd4, 9'b1_0000_0001});
        end

        // Async reset clears halt immediately
        rst_n = 1'b0;
        #1;
        check_now("halt_rst_async", 12'h000);
        @(posedge clk);
        #1;
        cycle("halt_rst_hold", 12'h000);
        rst_n = 1'b1;
        run_instr("lda_after_halt", LDA, 1'b0, m_alu, 8);

        // STO aborted by async reset in ALU_OP: no wr, phase 0 before next edge
        wr_watch = 1'b1;
        run_instr("sto_abort", STO, 1'b0, m_sto, 6);
        check_now("sto_abort_ph6", vec(6, m_sto));
        #1;
        rst_n = 1'b0;
        #1;
        check_now("sto_abort_async", 12'h000);
        @(posedge clk);
        #1;
        cycle("sto_abort_hold", 12'h000);
        wr_watch = 1'b0;
        checks++;
        if (wr_seen != 0) begin
            failures++;
            $display("FAIL sto_abort_wr: actual wr pulses=%0d required=0", wr_seen);
        end
        rst_n = 1'b1;
        run_instr("sto_after_abort", STO, 1'b0, m_sto, 8);

        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: actual pending=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
